// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: dual-port 32-bit word RAM with a registered read pipeline per port.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range accesses set err, drop writes, and read back zero.

module cpu_mem_rd_port #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_acc_i,
  input  logic [31:0] rd_word_i,
  output logic        busy_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);
  typedef enum logic {IDLE, WAIT} state_e;
  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d, rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Array word is captured at the accepting edge; it is only released to rdata on completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_acc_i) begin
          if (READ_LAT == 1) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word_i;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
            pend_d  = rd_word_i;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = pend_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q == WAIT);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
endmodule

module cpu_mem_responder #(
  parameter int DEPTH    = 2048,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req1,
  input  logic        w_en1,
  input  logic [10:0] addr1,
  input  logic [31:0] wdata1,
  output logic        busy1,
  output logic [31:0] rdata1,
  output logic        rvalid1,
  input  logic        req2,
  input  logic        w_en2,
  input  logic [10:0] addr2,
  input  logic [31:0] wdata2,
  output logic        busy2,
  output logic [31:0] rdata2,
  output logic        rvalid2,
  output logic        err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NP = 2;

  logic [31:0] mem [DEPTH];

  logic [NP-1:0]           req, wen, busy, rvalid, acc, wr_acc, rd_acc, oob;
  logic [NP-1:0][10:0]     addr;
  logic [NP-1:0][AW-1:0]   idx;
  logic [NP-1:0][31:0]     wdata, rd_word, rdata;

  assign req   = {req2, req1};
  assign wen   = {w_en2, w_en1};
  assign addr  = {addr2, addr1};
  assign wdata = {wdata2, wdata1};

  for (genvar p = 0; p < NP; p++) begin : g_port
    // Upper address bits beyond the array size alias onto the low words.
    assign idx[p] = addr[p][AW-1:0];
`ifdef MEM_BOUNDS_CHECK_EN
    assign oob[p] = 32'(addr[p]) >= 32'(DEPTH);
`else
    assign oob[p] = 1'b0;
`endif
    assign acc[p]     = req[p] & ~busy[p];
    assign wr_acc[p]  = acc[p] & wen[p] & ~oob[p];
    assign rd_acc[p]  = acc[p] & ~wen[p];
    assign rd_word[p] = oob[p] ? 32'h0 : mem[idx[p]];

    cpu_mem_rd_port #(.READ_LAT(READ_LAT)) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_acc_i (rd_acc[p]),
      .rd_word_i(rd_word[p]),
      .busy_o   (busy[p]),
      .rvalid_o (rvalid[p]),
      .rdata_o  (rdata[p])
    );
  end

  // Port 2 is written last, so it wins a same-address collision; reads see pre-edge data.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (wr_acc[p]) mem[idx[p]] <= wdata[p];
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err_q <= 1'b0;
    else if (|(acc & oob))   err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy1   = busy[0];
  assign busy2   = busy[1];
  assign rvalid1 = rvalid[0];
  assign rvalid2 = rvalid[1];
  assign rdata1  = rdata[0];
  assign rdata2  = rdata[1];
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench: four responder instances (LAT 1/3/4, and a 1024-word LAT 1 array).
module tb_cpu_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit OOB = 1'b1;
`else
  localparam bit OOB = 1'b0;
`endif

  logic [3:0]       req1, w_en1, busy1, rvalid1, req2, w_en2, busy2, rvalid2, err;
  logic [3:0][10:0] addr1, addr2;
  logic [3:0][31:0] wdata1, rdata1, wdata2, rdata2;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cpu_mem_responder #(
      .DEPTH   (g == 3 ? 1024 : 2048),
      .READ_LAT(g == 1 ? 3 : (g == 2 ? 4 : 1))
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req1(req1[g]), .w_en1(w_en1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
      .busy1(busy1[g]), .rdata1(rdata1[g]), .rvalid1(rvalid1[g]),
      .req2(req2[g]), .w_en2(w_en2[g]), .addr2(addr2[g]), .wdata2(wdata2[g]),
      .busy2(busy2[g]), .rdata2(rdata2[g]), .rvalid2(rvalid2[g]),
      .err(err[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic r1; logic w1; logic [10:0] a1; logic [31:0] d1;
    logic r2; logic w2; logic [10:0] a2; logic [31:0] d2;
    logic rv1; logic [31:0] rd1; logic rv2; logic [31:0] rd2;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req1 = '0; w_en1 = '0; addr1 = '0; wdata1 = '0;
    req2 = '0; w_en2 = '0; addr2 = '0; wdata2 = '0;
  endtask

  logic exp_busy[6];
  logic exp_rv[6];
  bit   seen;
  int   lat;

  initial begin
    tbl[0] = '{1, 1, 11'd0, 32'hE3A0_1005, 0, 0, 11'd0, 32'h0, 0, 32'h0,         0, 32'h0};
    tbl[1] = '{1, 0, 11'd0, 32'h0,         0, 0, 11'd0, 32'h0, 1, 32'hE3A0_1005, 0, 32'h0};
    tbl[2] = '{1, 1, 11'd5, 32'h1111_1111, 0, 0, 11'd0, 32'h0, 0, 32'hE3A0_1005, 0, 32'h0};
    tbl[3] = '{1, 0, 11'd5, 32'h0,         1, 1, 11'd5, 32'h2222_2222, 1, 32'h1111_1111, 0, 32'h0};
    tbl[4] = '{1, 0, 11'd5, 32'h0,         0, 0, 11'd0, 32'h0, 1, 32'h2222_2222, 0, 32'h0};
    tbl[5] = '{1, 1, 11'd7, 32'hA,         1, 1, 11'd7, 32'hB, 0, 32'h2222_2222, 0, 32'h0};
    tbl[6] = '{1, 0, 11'd0, 32'h0,         1, 0, 11'd7, 32'h0, 1, 32'hE3A0_1005, 1, 32'hB};
    tbl[7] = '{1, 1, 11'd0, 32'h1234_5678, 1, 0, 11'd0, 32'h0, 0, 32'hE3A0_1005, 1, 32'hE3A0_1005};
    tbl[8] = '{1, 0, 11'd7, 32'h0,         1, 0, 11'd0, 32'h0, 1, 32'hB, 1, 32'h1234_5678};
    tbl[9] = '{0, 0, 11'd0, 32'h0,         0, 0, 11'd0, 32'h0, 0, 32'hB, 0, 32'h1234_5678};

    // Reset values
    idle_all();
    rst_n = 1'b0;
    #12;
    chk("reset ctl bits", 32'({busy1, busy2, rvalid1, rvalid2, err}), 32'h0);
    chk("reset rdata1", rdata1[0], 32'h0);
    chk("reset rdata2", rdata2[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // LAT=1 table: writes, back-to-back reads, collisions
    for (int i = 0; i < 10; i++) begin
      req1[0] = tbl[i].r1; w_en1[0] = tbl[i].w1; addr1[0] = tbl[i].a1; wdata1[0] = tbl[i].d1;
      req2[0] = tbl[i].r2; w_en2[0] = tbl[i].w2; addr2[0] = tbl[i].a2; wdata2[0] = tbl[i].d2;
      tick();
      chk($sformatf("vec%0d rvalid1", i), 32'(rvalid1[0]), 32'(tbl[i].rv1));
      chk($sformatf("vec%0d rdata1", i), rdata1[0], tbl[i].rd1);
      chk($sformatf("vec%0d rvalid2", i), 32'(rvalid2[0]), 32'(tbl[i].rv2));
      chk($sformatf("vec%0d rdata2", i), rdata2[0], tbl[i].rd2);
      chk($sformatf("vec%0d busy", i), 32'({busy1[0], busy2[0]}), 32'h0);
    end

    // Asynchronous reset mid-cycle clears outputs at once
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst rdata1", rdata1[0], 32'h0);
    chk("async rst rdata2", rdata2[0], 32'h0);
    chk("async rst ctl", 32'({busy1, busy2, rvalid1, rvalid2}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LAT=3: busy for two cycles, held request re-accepted only once idle
    idle_all();
    req2[1] = 1; w_en2[1] = 1; addr2[1] = 11'd10; wdata2[1] = 32'hAA;
    req1[1] = 1; w_en1[1] = 1; addr1[1] = 11'd11; wdata1[1] = 32'h55;
    tick();
    chk("lat3 write busy2", 32'(busy2[1]), 32'h0);
    req1[1] = 0; w_en1[1] = 0; w_en2[1] = 0;
    exp_busy = '{1, 1, 0, 1, 1, 0};
    exp_rv   = '{0, 0, 1, 0, 0, 1};
    for (int c = 0; c < 6; c++) begin
      tick();
      addr2[1] = 11'd11;
      chk($sformatf("lat3 c%0d busy2", c), 32'(busy2[1]), 32'(exp_busy[c]));
      chk($sformatf("lat3 c%0d rvalid2", c), 32'(rvalid2[1]), 32'(exp_rv[c]));
      if (c == 2) chk("lat3 first rdata2", rdata2[1], 32'hAA);
      if (c == 5) chk("lat3 second rdata2", rdata2[1], 32'h55);
    end
    req2[1] = 0;
    tick();
    chk("lat3 rvalid2 drops", 32'(rvalid2[1]), 32'h0);
    chk("lat3 rdata2 held", rdata2[1], 32'h55);

    // LAT=4: reset two cycles after accept drops the read
    idle_all();
    req2[2] = 1; w_en2[2] = 1; addr2[2] = 11'd3; wdata2[2] = 32'hCAFE_F00D;
    tick();
    w_en2[2] = 0;
    tick();
    chk("lat4 busy after accept", 32'(busy2[2]), 32'h1);
    req2[2] = 0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("lat4 busy2 in reset", 32'(busy2[2]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rvalid2[2]) seen = 1'b1;
    end
    chk("lat4 no rvalid after reset", 32'(seen), 32'h0);
    chk("lat4 busy2 idle", 32'(busy2[2]), 32'h0);
    req2[2] = 1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      tick();
      req2[2] = 0;
      lat++;
      if (rvalid2[2]) seen = 1'b1;
    end
    chk("lat4 latency", 32'(lat), 32'd4);
    chk("lat4 rdata2", rdata2[2], 32'hCAFE_F00D);

    // DEPTH=1024: out-of-range address (flag/drop/zero, or alias)
    idle_all();
    req1[3] = 1; w_en1[3] = 1; addr1[3] = 11'd476; wdata1[3] = 32'h0047_6476;
    tick();
    idle_all();
    req2[3] = 1; w_en2[3] = 1; addr2[3] = 11'd1500; wdata2[3] = 32'hDEAD_BEEF;
    tick();
    chk("oob write err", 32'(err[3]), 32'(OOB));
    idle_all();
    tick();
    chk("oob err sticky", 32'(err[3]), 32'(OOB));
    req1[3] = 1; addr1[3] = 11'd476;
    req2[3] = 1; addr2[3] = 11'd1500;
    tick();
    chk("oob addr476 rvalid1", 32'(rvalid1[3]), 32'h1);
    chk("oob addr476 rdata1", rdata1[3], OOB ? 32'h0047_6476 : 32'hDEAD_BEEF);
    chk("oob read rvalid2", 32'(rvalid2[3]), 32'h1);
    chk("oob read rdata2", rdata2[3], OOB ? 32'h0 : 32'hDEAD_BEEF);
    chk("oob err after read", 32'(err[3]), 32'(OOB));
    idle_all();
    #2 rst_n = 1'b0;
    #1;
    chk("err cleared by reset", 32'(err[3]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's two RAM ports.
- Port 1 returns instruction words addressed by the PC; it also accepts program-load writes.
- Port 2 serves LDR/STR reads and writes using the ALU-computed address.
- Each port holds a registered, request/accept pipeline with programmable read latency, so the CPU controller can stall in its waiting state until read data is valid.

Parameters:
- DEPTH, 2048, number of 32-bit words; the address width is fixed at 11 bits.
- READ_LAT, 1, cycles from accepted read to rdata_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req1  in  1  port-1 request (fetch or program write).
- w_en1  in  1  port-1 write qualifier; sampled with req1.
- addr1  in  11  port-1 word address (PC).
- wdata1  in  32  port-1 write data.
- busy1  out  1  port-1 cannot accept a request this cycle.
- rdata1  out  32  port-1 read data (instr).
- rvalid1  out  1  one-cycle pulse; rdata1 is valid.
- req2  in  1  port-2 request.
- w_en2  in  1  port-2 write qualifier.
- addr2  in  11  port-2 word address.
- wdata2  in  32  port-2 store data.
- busy2  out  1  port-2 cannot accept.
- rdata2  out  32  port-2 load data.
- rvalid2  out  1  one-cycle pulse; rdata2 is valid.
- err  out  1  sticky address error; valid only with MEM_BOUNDS_CHECK_EN.

Behaviour:
- Reset values:
  - busy1 = busy2 = 0, rvalid1 = rvalid2 = 0, rdata1 = rdata2 = 0, err = 0.
  - Pending read pipelines are cleared.
  - Memory array contents are NOT reset.
- Reset mid-operation: any in-flight read is dropped; no rvalid pulse occurs after rst_n deasserts.
- Acceptance: a request is accepted at a clock edge where req & !busy. Requests while busy are ignored, not queued; the initiator holds req.
- Writes (req & w_en):
  - Array updated at the accepting edge; the port never goes busy.
  - No rvalid; rdata unchanged.
- Reads (req & !w_en):
  - Address and array word are captured at the accepting edge.
  - rvalid pulses high exactly READ_LAT cycles later, with rdata held valid from that cycle until the next read completes.
  - Per-port state machine IDLE -> WAIT(count) -> IDLE:
    - IDLE: busy = 0.
    - Accepted read with READ_LAT = 1: stay IDLE and pulse rvalid at the next edge, giving back-to-back reads at one per cycle.
    - Accepted read with READ_LAT > 1: go to WAIT with counter = READ_LAT-1, busy = 1. The counter decrements each cycle; at 1, the next edge sets rvalid and returns to IDLE.
  - A new request may be accepted on the same edge rvalid is asserted.
- Read-during-write:
  - Same port, same cycle: impossible, since one operation per port per cycle.
  - Port-1 read and port-2 write to the same address on the same edge: the read returns OLD data (read-first). The same applies to the reverse pairing.
- Simultaneous writes to the same address on both ports: port 2 wins; the port-1 data is discarded.
- Address arithmetic:
  - Addresses are word indices; no byte lanes.
  - With DEPTH < 2048 and the feature disabled, address bits above clog2(DEPTH) are ignored (wrap-around alias).
- Ports are fully independent apart from the collision rules above.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - An accepted request with addr >= DEPTH sets err (sticky until reset).
  - An out-of-range write is dropped.
  - An out-of-range read still completes with normal latency, but rdata = 32'h0000_0000.
- Undefined:
  - err is tied to 0.
  - Addresses wrap modulo DEPTH as described above.

Test Plan:
- Reset and read, READ_LAT = 1:
  - Assert rst_n low mid-cycle -> all outputs 0 immediately.
  - Release, write 32'hE3A0_1005 at addr1 = 0, then read addr1 = 0 -> rvalid1 one cycle later with rdata1 = 32'hE3A0_1005, busy1 never high.
- Latency, READ_LAT = 3:
  - Read addr2 = 10 holding 32'h0000_00AA -> busy2 high for 2 cycles, rvalid2 on the 3rd edge with rdata2 = 32'hAA.
  - req2 held during busy -> no second accept until IDLE.
- Cross-port collision:
  - addr 5 holds 32'h1111_1111; same edge: port-1 read of addr 5 and port-2 write of 32'h2222_2222 to addr 5 -> rdata1 = 32'h1111_1111.
  - A following read of addr 5 -> 32'h2222_2222.
- Dual write conflict:
  - Both ports write addr 7 (port 1 32'hA, port 2 32'hB) -> read back 32'hB.
- Reset mid-read, READ_LAT = 4:
  - Pulse rst_n low 2 cycles after accept -> rvalid2 never asserts.
  - busy2 = 0 after reset.
- MEM_BOUNDS_CHECK_EN, DEPTH = 1024:
  - Write addr2 = 1500 -> err = 1, array unchanged (addr 476 keeps its old value).
  - Read addr2 = 1500 -> rvalid2 with rdata2 = 0.
  - err stays 1 until rst_n goes low.
